// File: rtl/serv_rf_ram_arb_if.sv
// rtl/serv_rf_ram_arb_if.sv - core, debug and RF RAM signal bundle for serv_rf_ram_arb
interface serv_rf_ram_arb_if #(
  parameter int width = 8,
  parameter int AW    = 8
);
  // Core side (serv_rf_ram_if)
  logic             i_core_rreq;
  logic             i_core_wreq;
  logic             o_core_rreq;
  logic             o_core_wreq;
  logic [AW-1:0]    i_core_waddr;
  logic [width-1:0] i_core_wdata;
  logic             i_core_wen;
  logic [AW-1:0]    i_core_raddr;
  logic             i_core_ren;
  logic [width-1:0] o_core_rdata;
  // Debug / loader port
  logic             i_dbg_req;
  logic             i_dbg_we;
  logic [AW-1:0]    i_dbg_addr;
  logic [width-1:0] i_dbg_wdata;
  logic             o_dbg_ack;
  logic [width-1:0] o_dbg_rdata;
  // RF RAM port pair
  logic [AW-1:0]    o_waddr;
  logic [width-1:0] o_wdata;
  logic             o_wen;
  logic [AW-1:0]    o_raddr;
  logic             o_ren;
  logic [width-1:0] i_rdata;
  // Sticky protocol error
  logic             o_err;

  // Arbiter view
  modport slave (
    input  i_core_rreq, i_core_wreq, i_core_waddr, i_core_wdata, i_core_wen,
           i_core_raddr, i_core_ren, i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
           i_rdata,
    output o_core_rreq, o_core_wreq, o_core_rdata, o_dbg_ack, o_dbg_rdata,
           o_waddr, o_wdata, o_wen, o_raddr, o_ren, o_err
  );

  // Environment view (core, debugger and RAM together)
  modport master (
    output i_core_rreq, i_core_wreq, i_core_waddr, i_core_wdata, i_core_wen,
           i_core_raddr, i_core_ren, i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
           i_rdata,
    input  o_core_rreq, o_core_wreq, o_core_rdata, o_dbg_ack, o_dbg_rdata,
           o_waddr, o_wdata, o_wen, o_raddr, o_ren, o_err
  );
endinterface

// File: rtl/serv_rf_ram_arb.sv
// rtl/serv_rf_ram_arb.sv - shares the SERV RF RAM port pair between the core and a debug port
module serv_rf_ram_arb #(
  parameter int width = 8,
  parameter int AW    = 8,
  parameter int QUIET = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  serv_rf_ram_arb_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORE,
    S_DBG_RD,
    S_DBG_RCAP,
    S_DBG_WR
  } state_t;

  localparam logic [3:0] QUIET_CNT = 4'(QUIET);

  state_t           state_q, state_d;
  logic             rpend_q, rpend_d;
  logic             wpend_q, wpend_d;
  logic             last_dbg_q, last_dbg_d;
  logic             err_q, err_d;
  logic [3:0]       quiet_q, quiet_d;
  logic [width-1:0] dbg_rdata_q, dbg_rdata_d;

  logic             core_en;
  logic             core_rreq_all;
  logic             core_wreq_all;
  logic             core_pend;
  logic             fwd;
  logic             pass;

  logic             core_rreq;
  logic             core_wreq;
  logic             dbg_ack;
  logic [width-1:0] dbg_rdata;
  logic [AW-1:0]    waddr;
  logic [width-1:0] wdata;
  logic             wen;
  logic [AW-1:0]    raddr;
  logic             ren;

  assign core_en       = bus.i_core_ren | bus.i_core_wen;
  assign core_rreq_all = rpend_q | bus.i_core_rreq;
  assign core_wreq_all = wpend_q | bus.i_core_wreq;
  assign core_pend     = core_rreq_all | core_wreq_all;

  // Arbitration, next-state and RAM port steering
  always_comb begin
    state_d     = state_q;
    rpend_d     = core_rreq_all;
    wpend_d     = core_wreq_all;
    last_dbg_d  = last_dbg_q;
    quiet_d     = quiet_q;
    err_d       = err_q;
    dbg_rdata_d = dbg_rdata_q;
    fwd         = 1'b0;
    pass        = 1'b0;
    dbg_ack     = 1'b0;
    dbg_rdata   = dbg_rdata_q;
    waddr       = '0;
    wdata       = '0;
    wen         = 1'b0;
    raddr       = '0;
    ren         = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Live core enables always win: the core is mid-transaction and cannot wait.
        if (core_en || (core_pend && (!bus.i_dbg_req || last_dbg_q))) begin
          fwd        = 1'b1;
          pass       = 1'b1;
          state_d    = S_CORE;
          last_dbg_d = 1'b0;
          quiet_d    = '0;
        end else if (bus.i_dbg_req) begin
          state_d    = bus.i_dbg_we ? S_DBG_WR : S_DBG_RD;
          last_dbg_d = 1'b1;
        end
      end
      S_CORE: begin
        fwd  = 1'b1;
        pass = 1'b1;
        if (core_en || core_pend) begin
          quiet_d = '0;
        end else begin
          quiet_d = quiet_q + 4'd1;
          if (quiet_d == QUIET_CNT) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DBG_RD: begin
        ren     = 1'b1;
        raddr   = bus.i_dbg_addr;
        state_d = S_DBG_RCAP;
        if (core_en) err_d = 1'b1;
      end
      S_DBG_RCAP: begin
        dbg_rdata   = bus.i_rdata;
        dbg_rdata_d = bus.i_rdata;
        dbg_ack     = 1'b1;
        state_d     = S_IDLE;
        if (core_en) err_d = 1'b1;
      end
      S_DBG_WR: begin
        wen     = 1'b1;
        waddr   = bus.i_dbg_addr;
        wdata   = bus.i_dbg_wdata;
        dbg_ack = 1'b1;
        state_d = S_IDLE;
        if (core_en) err_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Forwarded pulses consume the pending flags in the same cycle.
    if (fwd) begin
      rpend_d = 1'b0;
      wpend_d = 1'b0;
    end

    if (pass) begin
      waddr = bus.i_core_waddr;
      wdata = bus.i_core_wdata;
      wen   = bus.i_core_wen;
      raddr = bus.i_core_raddr;
      ren   = bus.i_core_ren;
    end

    core_rreq = fwd & core_rreq_all;
    core_wreq = fwd & core_wreq_all;

    // Keep every driven output quiet while reset is held, not just after the next edge.
    if (!i_rst_n) begin
      core_rreq = 1'b0;
      core_wreq = 1'b0;
      dbg_ack   = 1'b0;
      dbg_rdata = '0;
      waddr     = '0;
      wdata     = '0;
      wen       = 1'b0;
      raddr     = '0;
      ren       = 1'b0;
    end
  end

  // State, pending flags, quiet counter, last grant, debug read data and error flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      rpend_q     <= 1'b0;
      wpend_q     <= 1'b0;
      last_dbg_q  <= 1'b0;
      err_q       <= 1'b0;
      quiet_q     <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rpend_q     <= rpend_d;
      wpend_q     <= wpend_d;
      last_dbg_q  <= last_dbg_d;
      err_q       <= err_d;
      quiet_q     <= quiet_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign bus.o_core_rreq  = core_rreq;
  assign bus.o_core_wreq  = core_wreq;
  assign bus.o_core_rdata = bus.i_rdata;
  assign bus.o_dbg_ack    = dbg_ack;
  assign bus.o_dbg_rdata  = dbg_rdata;
  assign bus.o_waddr      = waddr;
  assign bus.o_wdata      = wdata;
  assign bus.o_wen        = wen;
  assign bus.o_raddr      = raddr;
  assign bus.o_ren        = ren;
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_serv_rf_ram_arb.sv
// tb/tb_serv_rf_ram_arb.sv - self-checking bench for serv_rf_ram_arb
module tb_serv_rf_ram_arb;
  localparam int W     = 8;
  localparam int AW    = 8;
  localparam int QUIET = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serv_rf_ram_arb_if #(.width(W), .AW(AW)) bus ();

  serv_rf_ram_arb #(.width(W), .AW(AW), .QUIET(QUIET)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // RF RAM: synchronous write, one-cycle read latency
  logic [W-1:0] ram [256];
  logic [W-1:0] rdata_q;
  always @(posedge clk) begin
    if (bus.o_wen) ram[bus.o_waddr] <= bus.o_wdata;
    if (bus.o_ren) rdata_q <= ram[bus.o_raddr];
  end
  assign bus.i_rdata = rdata_q;

  // Expected RAM contents, updated from what the bench asks for
  logic [W-1:0] shadow [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_wait();
    repeat (QUIET + 2) tick();
  endtask

  task automatic dbg_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                            output logic [7:0] rd, output int lat);
    bus.i_dbg_req = 1'b1; bus.i_dbg_we = we; bus.i_dbg_addr = a; bus.i_dbg_wdata = d;
    lat = -1; rd = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.o_dbg_ack === 1'b1) begin lat = n; rd = bus.o_dbg_rdata; break; end
      tick();
    end
    tick();
    bus.i_dbg_req = 1'b0;
    if (we) shadow[a] = d;
  endtask

  task automatic test_reset();
    bus.i_core_ren = 1'b1; bus.i_core_raddr = 8'h55;
    repeat (2) @(negedge clk);
    checks++; if ({bus.o_core_rreq, bus.o_core_wreq, bus.o_dbg_ack, bus.o_dbg_rdata, bus.o_waddr, bus.o_wdata, bus.o_wen, bus.o_raddr, bus.o_ren, bus.o_err} !== '0)
      begin errors++; $display("FAIL reset_outputs: got ren=%0h raddr=%0h err=%0h, expected all 0", bus.o_ren, bus.o_raddr, bus.o_err); end
    bus.i_core_ren = 1'b0; bus.i_core_raddr = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_dbg_write();
    bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b1; bus.i_dbg_addr = 8'h10; bus.i_dbg_wdata = 8'h3C;
    @(negedge clk);
    checks++; if ({bus.o_wen, bus.o_dbg_ack} !== 2'b00) begin errors++; $display("FAIL dbg_wr_grant_cycle: got wen/ack=%b expected 00", {bus.o_wen, bus.o_dbg_ack}); end
    tick();
    @(negedge clk);
    checks++; if ({bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_dbg_ack} !== {1'b1, 8'h10, 8'h3C, 1'b1})
      begin errors++; $display("FAIL dbg_wr_strobe: got wen=%0h waddr=%0h wdata=%0h ack=%0h expected 1 10 3c 1", bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_dbg_ack); end
    tick();
    bus.i_dbg_req = 1'b0; shadow[8'h10] = 8'h3C;
    @(negedge clk);
    checks++; if ({bus.o_wen, bus.o_dbg_ack} !== 2'b00) begin errors++; $display("FAIL dbg_wr_single_ack: got wen/ack=%b expected 00", {bus.o_wen, bus.o_dbg_ack}); end
    tick();
  endtask

  task automatic test_dbg_read();
    logic [7:0] rd; int lat;
    // Core writes 0xA5 to 0x05 first
    bus.i_core_wreq = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_core_wreq !== 1'b1) begin errors++; $display("FAIL core_wreq_fwd: got %0h expected 1", bus.o_core_wreq); end
    tick();
    bus.i_core_wreq = 1'b0; bus.i_core_wen = 1'b1; bus.i_core_waddr = 8'h05; bus.i_core_wdata = 8'hA5;
    @(negedge clk);
    checks++; if ({bus.o_wen, bus.o_waddr, bus.o_wdata} !== {1'b1, 8'h05, 8'hA5}) begin errors++; $display("FAIL core_wr_pass: got wen=%0h waddr=%0h wdata=%0h expected 1 5 a5", bus.o_wen, bus.o_waddr, bus.o_wdata); end
    tick();
    bus.i_core_wen = 1'b0; shadow[8'h05] = 8'hA5;
    idle_wait();
    bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b0; bus.i_dbg_addr = 8'h05;
    @(negedge clk);
    checks++; if (bus.o_ren !== 1'b0) begin errors++; $display("FAIL dbg_rd_grant_cycle: got ren=%0h expected 0", bus.o_ren); end
    tick();
    @(negedge clk);
    checks++; if ({bus.o_ren, bus.o_raddr, bus.o_dbg_ack} !== {1'b1, 8'h05, 1'b0}) begin errors++; $display("FAIL dbg_rd_strobe: got ren=%0h raddr=%0h ack=%0h expected 1 5 0", bus.o_ren, bus.o_raddr, bus.o_dbg_ack); end
    tick();
    @(negedge clk);
    checks++; if ({bus.o_dbg_ack, bus.o_dbg_rdata} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL dbg_rd_ack: got ack=%0h rdata=%0h expected 1 a5", bus.o_dbg_ack, bus.o_dbg_rdata); end
    tick();
    bus.i_dbg_req = 1'b0;
    @(negedge clk);
    checks++; if ({bus.o_dbg_ack, bus.o_dbg_rdata} !== {1'b0, 8'hA5}) begin errors++; $display("FAIL dbg_rd_hold: got ack=%0h rdata=%0h expected 0 a5", bus.o_dbg_ack, bus.o_dbg_rdata); end
    tick();
    dbg_access(1'b0, 8'h10, 8'h00, rd, lat);
    checks++; if ({rd, lat} !== {8'h3C, 32'sd2}) begin errors++; $display("FAIL dbg_rd_after_wr: got rdata=%0h lat=%0d expected 3c 2", rd, lat); end
  endtask

  task automatic test_core_only();
    logic [7:0] rd; int lat;
    bus.i_core_rreq = 1'b1;
    @(negedge clk);
    checks++; if (bus.o_core_rreq !== 1'b1) begin errors++; $display("FAIL core_rreq_same_cycle: got %0h expected 1", bus.o_core_rreq); end
    tick();
    bus.i_core_rreq = 1'b0; bus.i_core_ren = 1'b1; bus.i_core_raddr = 8'h1A;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if ({bus.o_ren, bus.o_raddr, bus.o_core_rreq} !== {1'b1, 8'h1A, 1'b0}) begin errors++; $display("FAIL core_ren_pass[%0d]: got ren=%0h raddr=%0h rreq=%0h expected 1 1a 0", i, bus.o_ren, bus.o_raddr, bus.o_core_rreq); end
      tick();
    end
    bus.i_core_ren = 1'b0;
    // Debug waits out the quiet window: QUIET core cycles, then grant, then write cycle
    dbg_access(1'b1, 8'h20, 8'h77, rd, lat);
    checks++; if (lat !== QUIET + 1) begin errors++; $display("FAIL quiet_window: got ack after %0d cycles expected %0d", lat, QUIET + 1); end
  endtask

  task automatic test_contention();
    logic [7:0] rd; int lat;
    // Make the core the last grantee
    bus.i_core_rreq = 1'b1;
    tick();
    bus.i_core_rreq = 1'b0;
    idle_wait();
    bus.i_core_rreq = 1'b1; bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b0; bus.i_dbg_addr = 8'h10;
    @(negedge clk);
    checks++; if (bus.o_core_rreq !== 1'b0) begin errors++; $display("FAIL cont_a_core_held: got rreq=%0h expected 0", bus.o_core_rreq); end
    tick();
    bus.i_core_rreq = 1'b0;
    @(negedge clk);
    checks++; if ({bus.o_ren, bus.o_raddr, bus.o_core_rreq} !== {1'b1, 8'h10, 1'b0}) begin errors++; $display("FAIL cont_a_dbg_first: got ren=%0h raddr=%0h rreq=%0h expected 1 10 0", bus.o_ren, bus.o_raddr, bus.o_core_rreq); end
    tick();
    @(negedge clk);
    checks++; if ({bus.o_dbg_ack, bus.o_dbg_rdata} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL cont_a_ack: got ack=%0h rdata=%0h expected 1 3c", bus.o_dbg_ack, bus.o_dbg_rdata); end
    tick();
    bus.i_dbg_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_core_rreq !== 1'b1) begin errors++; $display("FAIL cont_a_core_after: got rreq=%0h expected 1", bus.o_core_rreq); end
    tick();
    idle_wait();
    // Make debug the last grantee, then collide again
    dbg_access(1'b1, 8'h30, 8'h5A, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL cont_b_setup_lat: got %0d expected 1", lat); end
    bus.i_core_rreq = 1'b1; bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b0; bus.i_dbg_addr = 8'h30;
    @(negedge clk);
    checks++; if ({bus.o_core_rreq, bus.o_ren} !== 2'b10) begin errors++; $display("FAIL cont_b_core_first: got rreq/ren=%b expected 10", {bus.o_core_rreq, bus.o_ren}); end
    lat = -1;
    for (int n = 1; n < 30; n++) begin
      tick();
      bus.i_core_rreq = 1'b0;
      @(negedge clk);
      if (bus.o_dbg_ack === 1'b1) begin lat = n; rd = bus.o_dbg_rdata; break; end
    end
    tick();
    bus.i_dbg_req = 1'b0;
    checks++; if ({rd, lat} !== {8'h5A, 32'(QUIET + 3)}) begin errors++; $display("FAIL cont_b_dbg_after: got rdata=%0h lat=%0d expected 5a %0d", rd, lat, QUIET + 3); end
  endtask

  task automatic test_protocol_err();
    bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b1; bus.i_dbg_addr = 8'h40; bus.i_dbg_wdata = 8'h11;
    tick();
    bus.i_core_wen = 1'b1; bus.i_core_waddr = 8'h41; bus.i_core_wdata = 8'hEE;
    @(negedge clk);
    checks++; if ({bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_dbg_ack, bus.o_err} !== {1'b1, 8'h40, 8'h11, 1'b1, 1'b0})
      begin errors++; $display("FAIL err_dbg_data_only: got wen=%0h waddr=%0h wdata=%0h ack=%0h err=%0h expected 1 40 11 1 0", bus.o_wen, bus.o_waddr, bus.o_wdata, bus.o_dbg_ack, bus.o_err); end
    tick();
    bus.i_core_wen = 1'b0; bus.i_dbg_req = 1'b0; shadow[8'h40] = 8'h11;
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL err_set: got %0h expected 1", bus.o_err); end
    repeat (6) tick();
    @(negedge clk);
    checks++; if (bus.o_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0h expected 1", bus.o_err); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] rd; int lat; int acks;
    bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b0; bus.i_dbg_addr = 8'h05;
    tick();
    @(negedge clk);
    checks++; if (bus.o_ren !== 1'b1) begin errors++; $display("FAIL rst_mid_in_rd: got ren=%0h expected 1", bus.o_ren); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({bus.o_ren, bus.o_raddr, bus.o_dbg_ack, bus.o_dbg_rdata, bus.o_err, bus.o_wen} !== '0)
      begin errors++; $display("FAIL rst_mid_outputs: got ren=%0h raddr=%0h ack=%0h rdata=%0h err=%0h expected all 0", bus.o_ren, bus.o_raddr, bus.o_dbg_ack, bus.o_dbg_rdata, bus.o_err); end
    tick();
    bus.i_dbg_req = 1'b0; rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.o_dbg_ack === 1'b1 || bus.o_ren === 1'b1) acks++;
      tick();
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL rst_mid_no_ack: got %0d strobes expected 0", acks); end
    dbg_access(1'b1, 8'h50, 8'h66, rd, lat);
    checks++; if ({lat, bus.o_err} !== {32'sd1, 1'b0}) begin errors++; $display("FAIL rst_mid_idle_after: got lat=%0d err=%0h expected 1 0", lat, bus.o_err); end
  endtask

  task automatic test_random();
    logic [7:0] rd, a, d, exp_rd;
    int lat, k;
    logic pend_rd;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom);
      dbg_access(1'b1, 8'h80 + 8'(i), d, rd, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL rnd_fill_lat[%0d]: got %0d expected 1", i, lat); end
    end
    for (int it = 0; it < 40; it++) begin
      a = 8'h80 + 8'($urandom_range(0, 15));
      d = 8'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          dbg_access(1'b1, a, d, rd, lat);
          checks++; if (lat !== 1) begin errors++; $display("FAIL rnd_dbg_wr[%0d]: got lat=%0d expected 1", it, lat); end
        end
        1: begin
          exp_rd = shadow[a];
          dbg_access(1'b0, a, 8'h00, rd, lat);
          checks++; if ({rd, lat} !== {exp_rd, 32'sd2}) begin errors++; $display("FAIL rnd_dbg_rd[%0d]: got rdata=%0h lat=%0d expected %0h 2", it, rd, lat, exp_rd); end
        end
        default: begin
          bus.i_core_rreq = 1'b1; bus.i_core_wreq = 1'b1;
          @(negedge clk);
          checks++; if ({bus.o_core_rreq, bus.o_core_wreq} !== 2'b11) begin errors++; $display("FAIL rnd_core_fwd[%0d]: got %b expected 11", it, {bus.o_core_rreq, bus.o_core_wreq}); end
          pend_rd = 1'b0; exp_rd = '0;
          k = $urandom_range(1, 6);
          for (int c = 0; c <= k; c++) begin
            tick();
            bus.i_core_rreq = 1'b0; bus.i_core_wreq = 1'b0;
            bus.i_core_ren = 1'b0; bus.i_core_wen = 1'b0;
            if (c < k) begin
              a = 8'h80 + 8'($urandom_range(0, 15));
              if ($urandom_range(0, 1) == 1) begin
                bus.i_core_wen = 1'b1; bus.i_core_waddr = a; bus.i_core_wdata = 8'($urandom);
                shadow[a] = bus.i_core_wdata;
              end else begin
                bus.i_core_ren = 1'b1; bus.i_core_raddr = a;
              end
            end
            @(negedge clk);
            if (pend_rd) begin
              checks++; if (bus.o_core_rdata !== exp_rd) begin errors++; $display("FAIL rnd_core_rd[%0d.%0d]: got %0h expected %0h", it, c, bus.o_core_rdata, exp_rd); end
            end
            pend_rd = bus.i_core_ren;
            exp_rd = shadow[bus.i_core_raddr];
          end
          tick();
          idle_wait();
        end
      endcase
    end
  endtask

  initial begin
    bus.i_core_rreq = 1'b0; bus.i_core_wreq = 1'b0; bus.i_core_waddr = '0; bus.i_core_wdata = '0;
    bus.i_core_wen = 1'b0; bus.i_core_raddr = '0; bus.i_core_ren = 1'b0;
    bus.i_dbg_req = 1'b0; bus.i_dbg_we = 1'b0; bus.i_dbg_addr = '0; bus.i_dbg_wdata = '0;
    test_reset();
    test_dbg_write();
    test_dbg_read();
    test_core_only();
    test_contention();
    test_protocol_err();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
